// File: rtl/id_ex_operand_stage.sv
// ID/EX operand-preparation stage: resolves EX/MEM and MEM/WB forwarding,
// selects the ALU operands, decodes the ALU control code, and holds one
// instruction for the ALU behind a valid/ready handshake with flush.
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic               alu_src,
  input  logic [1:0]         alu_op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write_in,
  input  logic               exm_wr,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_value,
  input  logic               mwb_wr,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]    mwb_value,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alu_control,
  output logic [XLEN-1:0]    operand_a,
  output logic [XLEN-1:0]    operand_b,
  output logic [XLEN-1:0]    store_data,
  output logic [RADDR_W-1:0] rd_out,
  output logic               reg_write_out
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [3:0]      alu_ctl_next;
  logic            take;

  // The slot can refill whenever it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data;
    fwd_rs2 = rs2_data;
    if (rs1_addr != '0) begin
      if (exm_wr && (exm_rd == rs1_addr))      fwd_rs1 = exm_value;
      else if (mwb_wr && (mwb_rd == rs1_addr)) fwd_rs1 = mwb_value;
    end
    if (rs2_addr != '0) begin
      if (exm_wr && (exm_rd == rs2_addr))      fwd_rs2 = exm_value;
      else if (mwb_wr && (mwb_rd == rs2_addr)) fwd_rs2 = mwb_value;
    end
  end

  // ALU control decode; funct7b5 only means subtract for register-register ops.
  always_comb begin
    alu_ctl_next = 4'b0010;
    case (alu_op)
      2'b01: alu_ctl_next = 4'b0110;
      2'b10: begin
        case (funct3)
          3'b000:  if (funct7b5 && !alu_src) alu_ctl_next = 4'b0110;
          3'b111:  alu_ctl_next = 4'b0000;
          3'b110:  alu_ctl_next = 4'b0001;
          default: alu_ctl_next = 4'b0010;
        endcase
      end
      default: alu_ctl_next = 4'b0010;
    endcase
  end

  // Pipeline register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      alu_control   <= 4'b0010;
      operand_a     <= '0;
      operand_b     <= '0;
      store_data    <= '0;
      rd_out        <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (take) begin
      out_valid     <= 1'b1;
      reg_write_out <= reg_write_in;
      alu_control   <= alu_ctl_next;
      operand_a     <= fwd_rs1;
      operand_b     <= alu_src ? imm : fwd_rs2;
      store_data    <= fwd_rs2;
      rd_out        <= rd_addr;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the held slot.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [RW-1:0]   rs1_addr, rs2_addr, rd_addr, exm_rd, mwb_rd, rd_out;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, exm_value, mwb_value;
  logic            alu_src, funct7b5, reg_write_in, exm_wr, mwb_wr, flush;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            out_valid, out_ready, reg_write_out;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a, operand_b, store_data;

  id_ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
    .rd_addr(rd_addr), .reg_write_in(reg_write_in),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_value(exm_value),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_value(mwb_value),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the single held instruction
  logic            mv, m_rw;
  logic [3:0]      m_ctl;
  logic [XLEN-1:0] m_a, m_b, m_sd;
  logic [RW-1:0]   m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] a, input logic [XLEN-1:0] d);
    if (a == 0) return d;
    if (exm_wr && exm_rd == a) return exm_value;
    if (mwb_wr && mwb_rd == a) return mwb_value;
    return d;
  endfunction

  function automatic logic [3:0] ctl_ref();
    logic is_sub;
    is_sub = (alu_op == 2'd1) ||
             (alu_op == 2'd2 && funct3 == 3'd0 && funct7b5 && !alu_src);
    if (is_sub) return 4'b0110;
    if (alu_op == 2'd2 && funct3 == 3'd7) return 4'b0000;
    if (alu_op == 2'd2 && funct3 == 3'd6) return 4'b0001;
    return 4'b0010;
  endfunction

  task automatic idle();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    alu_src = 0; alu_op = 0; funct3 = 0; funct7b5 = 0; rd_addr = 0; reg_write_in = 0;
    exm_wr = 0; exm_rd = 0; exm_value = 0; mwb_wr = 0; mwb_rd = 0; mwb_value = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    rs1_addr = RW'($urandom_range(0, 3)); rs2_addr = RW'($urandom_range(0, 3));
    rd_addr  = RW'($urandom_range(0, 31));
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    alu_src = 1'($urandom); alu_op = 2'($urandom); funct3 = 3'($urandom);
    funct7b5 = 1'($urandom); reg_write_in = 1'($urandom);
    exm_wr = 1'($urandom); exm_rd = RW'($urandom_range(0, 3)); exm_value = $urandom;
    mwb_wr = 1'($urandom); mwb_rd = RW'($urandom_range(0, 3)); mwb_value = $urandom;
    flush = ($urandom_range(0, 9) == 0);
    out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, mv);
    check("reg_write_out", reg_write_out, m_rw);
    if (mv) begin
      check("alu_control", alu_control, m_ctl);
      check("operand_a", operand_a, m_a);
      check("operand_b", operand_b, m_b);
      check("store_data", store_data, m_sd);
      check("rd_out", rd_out, m_rd);
    end
  endtask

  // Inputs are already applied at a falling edge; advance one clock and compare.
  task automatic cycle();
    #1;
    check("in_ready", in_ready, !mv || out_ready);
    if (flush) begin
      mv = 0; m_rw = 0;
    end else if (in_valid && (!mv || out_ready)) begin
      mv = 1; m_rw = reg_write_in; m_ctl = ctl_ref();
      m_a = fwd(rs1_addr, rs1_data);
      m_sd = fwd(rs2_addr, rs2_data);
      m_b = alu_src ? imm : m_sd;
      m_rd = rd_addr;
    end else if (mv && out_ready) begin
      mv = 0; m_rw = 0;
    end
    @(posedge clock);
    @(negedge clock);
    compare_outputs();
  endtask

  initial begin
    idle();
    reset = 1;
    mv = 0; m_rw = 0; m_ctl = 4'b0010; m_a = 0; m_b = 0; m_sd = 0; m_rd = 0;
    repeat (2) @(negedge clock);
    check("rst out_valid", out_valid, 1'b0);
    check("rst reg_write_out", reg_write_out, 1'b0);
    check("rst alu_control", alu_control, 4'b0010);
    check("rst operand_a", operand_a, 32'h0);
    check("rst operand_b", operand_b, 32'h0);
    check("rst store_data", store_data, 32'h0);
    check("rst rd_out", rd_out, 5'h0);
    reset = 0;

    // R-type subtract
    in_valid = 1; rs1_addr = 1; rs2_addr = 2; rs1_data = 10; rs2_data = 3;
    alu_op = 2'b10; funct3 = 3'b000; funct7b5 = 1; rd_addr = 3; reg_write_in = 1;
    cycle();
    check("sub valid", out_valid, 1'b1);
    check("sub ctl", alu_control, 4'b0110);
    check("sub a", operand_a, 32'd10);
    check("sub b", operand_b, 32'd3);

    // forwarding priority, back to back
    rs1_addr = 5; exm_wr = 1; exm_rd = 5; exm_value = 32'hAAAA;
    mwb_wr = 1; mwb_rd = 5; mwb_value = 32'hBBBB;
    cycle();
    check("fwd exm", operand_a, 32'hAAAA);
    exm_wr = 0;
    cycle();
    check("fwd mwb", operand_a, 32'hBBBB);
    rs1_addr = 0; rs1_data = 32'h1234; exm_wr = 1; exm_rd = 0; mwb_rd = 0;
    cycle();
    check("fwd x0", operand_a, 32'h1234);

    // I-type with immediate, store data still forwarded
    idle();
    in_valid = 1; alu_src = 1; imm = 32'hFFFF_FFFC; alu_op = 2'b10; funct3 = 3'b000;
    funct7b5 = 1; rs2_addr = 7; rs2_data = 55; mwb_wr = 1; mwb_rd = 7; mwb_value = 77;
    cycle();
    check("itype ctl", alu_control, 4'b0010);
    check("itype b", operand_b, 32'hFFFF_FFFC);
    check("itype sd", store_data, 32'd77);

    // stall with new offers, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); flush = 0; in_valid = 1; out_ready = 0;
      cycle();
      check("stall in_ready", in_ready, 1'b0);
    end
    rand_inputs(); flush = 0; in_valid = 1; out_ready = 1;
    cycle();
    check("release valid", out_valid, 1'b1);

    // flush beats a simultaneous transfer-in
    rand_inputs(); flush = 1; in_valid = 1; out_ready = 1; reg_write_in = 1;
    cycle();
    check("flush valid", out_valid, 1'b0);
    check("flush rw", reg_write_out, 1'b0);
    rand_inputs(); flush = 0; in_valid = 1;
    cycle();
    check("post flush valid", out_valid, 1'b1);

    // asynchronous reset while stalled
    rand_inputs(); flush = 0; in_valid = 1; out_ready = 0; reg_write_in = 1;
    cycle();
    check("pre reset valid", out_valid, 1'b1);
    #2 reset = 1;
    #1;
    check("async rst valid", out_valid, 1'b0);
    check("async rst ctl", alu_control, 4'b0010);
    check("async rst rw", reg_write_out, 1'b0);
    mv = 0; m_rw = 0;
    idle();
    @(negedge clock);
    reset = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register and operand-preparation stage directly upstream of the ALU.
- Accepts decoded instruction fields and register-file read data, and resolves EX/MEM and MEM/WB forwarding.
- Selects the register or immediate operand and generates the 4-bit ALU control code.
- Presents registered operands to the ALU under a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width of operands and immediates
- RADDR_W, 5, register index width

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream decode holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- rs1_addr  input  RADDR_W  source register 1 index
- rs2_addr  input  RADDR_W  source register 2 index
- rs1_data  input  XLEN  register-file read data 1
- rs2_data  input  XLEN  register-file read data 2
- imm  input  XLEN  sign-extended immediate
- alu_src  input  1  1 = operand B from imm, 0 = from rs2
- alu_op  input  2  00 = add (ld/st), 01 = sub (branch), 10 = R/I-type decode via funct
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- rd_addr  input  RADDR_W  destination index
- reg_write_in  input  1  instruction writes rd
- exm_wr  input  1  EX/MEM stage will write
- exm_rd  input  RADDR_W  EX/MEM destination
- exm_value  input  XLEN  EX/MEM result
- mwb_wr  input  1  MEM/WB stage will write
- mwb_rd  input  RADDR_W  MEM/WB destination
- mwb_value  input  XLEN  MEM/WB result
- flush  input  1  squash held and incoming instruction
- out_valid  output  1  ALU inputs valid
- out_ready  input  1  downstream consumes this cycle
- alu_control  output  4  ALU operation code
- operand_a  output  XLEN  ALU input1
- operand_b  output  XLEN  ALU input2
- store_data  output  XLEN  forwarded rs2 value, used for stores
- rd_out  output  RADDR_W  registered destination
- reg_write_out  output  1  registered write enable (0 when out_valid=0)

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, reg_write_out=0, alu_control=4'b0010, operand_a=0, operand_b=0, store_data=0, rd_out=0.
- Pipeline depth: one entry.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Transfer in: in_valid && in_ready at a rising edge. All outputs load next-stage values and out_valid becomes 1. Latency is exactly 1 cycle.
- Transfer out: out_valid && out_ready.
  - If no new transfer-in occurs in the same cycle, out_valid becomes 0.
  - Simultaneous in and out transfers give back-to-back throughput with no bubble.
- Stall: out_valid && !out_ready. All outputs hold their values bit-exact. Forwarding inputs are ignored while holding.
- Forwarding, evaluated combinationally on the transfer-in cycle, separately for rs1 and rs2:
  - Priority 1: exm_wr && exm_rd==rsX_addr && rsX_addr!=0 selects exm_value.
  - Priority 2: otherwise mwb_wr && mwb_rd==rsX_addr && rsX_addr!=0 selects mwb_value.
  - Otherwise rsX_data is used.
  - Index 0 is never forwarded. rs1_data/rs2_data are passed through unchanged for x0.
- Operand mapping:
  - operand_a = fwd_rs1.
  - operand_b = alu_src ? imm : fwd_rs2.
  - store_data = fwd_rs2, regardless of alu_src.
- ALU control:
  - alu_op=00 gives 0010 (add).
  - alu_op=01 gives 0110 (sub).
  - alu_op=10 decodes funct3:
    - 000 gives 0110 when funct7b5 && !alu_src, else 0010.
    - 111 gives 0000 (and).
    - 110 gives 0001 (or).
    - Any other funct3 gives 0010.
  - alu_op=11 gives 0010.
- Flush, sampled at the rising edge: out_valid becomes 0 and reg_write_out becomes 0. The incoming instruction is discarded even if in_valid=1. Data outputs are don't-care. Flush overrides stall and transfer-in.
- reg_write_out = 0 whenever out_valid=0.
- Reset asserted mid-stall: the held instruction is lost and out_valid=0 immediately (asynchronous). Deassertion takes effect at the next rising edge.
- No arithmetic is performed in this stage. Widths pass through unchanged, with no truncation or extension.

Test Plan:
- Reset mid-operation: assert reset while out_valid=1 and stalled -> out_valid=0 and alu_control=0010 within the same cycle, with no clock edge required.
- Basic R-type sub: rs1_data=10, rs2_data=3, alu_op=10, funct3=000, funct7b5=1, alu_src=0 -> one cycle later out_valid=1, alu_control=0110, operand_a=10, operand_b=3.
- Forwarding priority: rs1_addr=5 with exm_rd=5/exm_value=0xAAAA and mwb_rd=5/mwb_value=0xBBBB, both write enables 1 -> operand_a=0xAAAA.
  - With exm_wr=0 -> operand_a=0xBBBB.
  - With rs1_addr=0 -> operand_a=rs1_data.
- I-type with immediate: alu_src=1, imm=0xFFFFFFFC, funct3=000, funct7b5=1 -> alu_control=0010 (not sub), operand_b=0xFFFFFFFC, store_data=fwd_rs2.
- Stall hold: out_ready=0 for 3 cycles with new in_valid inputs presented -> in_ready=0 and outputs unchanged.
  - Then out_ready=1 with in_valid=1 -> new instruction loaded the next cycle with no bubble.
- Flush precedence: flush=1 together with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and reg_write_out=0.
  - The following accepted instruction appears normally.
